// File: rtl/mux4to1_sel.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux4to1_sel
//
// Purpose:
//   Single-bit 4:1 multiplexer with a purely combinational data path, plus
//   clocked bookkeeping around the select:
//     - a registered copy of the mux output,
//     - the select value registered,
//     - a one-cycle pulse whenever the select differs from last cycle's value,
//     - a saturating count of select changes.
//   The select is formed as {s1, s0}.
//
// Build option:
//   MUX4TO1_SEL_OUTREG_EN - when defined, out is driven from the output
//   register, which gives one cycle of latency and 0 during reset. When it is
//   undefined, out is the combinational mux. The port list and the behaviour
//   of out_q, sel_q, sel_chg and sel_cnt are identical in both builds.
//
// Parameters:
//   CNT_W   width of sel_cnt (1..32)
//
// Ports:
//   clk      in   rising-edge clock for all registers
//   rst      in   synchronous, active-high reset
//   s0, s1   in   select bits (s1 is the MSB)
//   in0..in3 in   data inputs for select 00/01/10/11
//   out      out  mux output (combinational, or registered with the option)
//   out_q    out  out registered one cycle
//   sel_q    out  {s1,s0} registered one cycle
//   sel_chg  out  one-cycle pulse when the select changed
//   sel_cnt  out  saturating count of select changes
// -----------------------------------------------------------------------------
module mux4to1_sel #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0,
    input  logic             s1,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    output logic             out,
    output logic             out_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sel_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sel_s;
    logic             mux_s;

    logic             out_reg_q;
    logic             out_reg_d;
    logic [1:0]       sel_reg_q;
    logic [1:0]       sel_reg_d;
    logic             chg_reg_q;
    logic             chg_reg_d;
    logic [CNT_W-1:0] cnt_reg_q;
    logic [CNT_W-1:0] cnt_reg_d;

    assign sel_s = {s1, s0};

    // Data-path mux; an X/Z select bit matches no item and falls to the X default.
    always_comb begin
        mux_s = 1'b0;
        case (sel_s)
            2'b00:   mux_s = in0;
            2'b01:   mux_s = in1;
            2'b10:   mux_s = in2;
            2'b11:   mux_s = in3;
            default: mux_s = 1'bx;
        endcase
    end

    // Next-state for the bookkeeping registers.
    always_comb begin
        out_reg_d = mux_s;
        sel_reg_d = sel_s;
        // Kept as a plain expression so an unknown select yields an unknown pulse.
        chg_reg_d = (sel_s != sel_reg_q);
        cnt_reg_d = cnt_reg_q;
        // An unknown change flag takes the else branch, so the count holds.
        if (chg_reg_d && (cnt_reg_q != CNT_MAX)) begin
            cnt_reg_d = cnt_reg_q + CNT_ONE;
        end else begin
            cnt_reg_d = cnt_reg_q;
        end
    end

    // Bookkeeping registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg_q <= 1'b0;
            sel_reg_q <= 2'b00;
            chg_reg_q <= 1'b0;
            cnt_reg_q <= CNT_ZERO;
        end else begin
            out_reg_q <= out_reg_d;
            sel_reg_q <= sel_reg_d;
            chg_reg_q <= chg_reg_d;
            cnt_reg_q <= cnt_reg_d;
        end
    end

    assign out_q   = out_reg_q;
    assign sel_q   = sel_reg_q;
    assign sel_chg = chg_reg_q;
    assign sel_cnt = cnt_reg_q;

`ifdef MUX4TO1_SEL_OUTREG_EN
    assign out = out_reg_q;
`else
    assign out = mux_s;
`endif

endmodule

// File: tb/tb_mux4to1_sel.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mux4to1_sel
//
// Scoreboard bench for mux4to1_sel (default build, CNT_W = 2 so saturation is
// reached quickly). The driver computes expected values from a behavioural
// model and pushes them into queues; two monitor processes pop and compare.
// -----------------------------------------------------------------------------
module tb_mux4to1_sel;

    localparam int CNT_W = 2;

    typedef struct {
        logic             out_q;
        logic [1:0]       sel;
        logic             chg;
        logic [CNT_W-1:0] cnt;
    } exp_reg_t;

    logic             clk;
    logic             rst;
    logic             s0;
    logic             s1;
    logic             in0;
    logic             in1;
    logic             in2;
    logic             in3;
    logic             out;
    logic             out_q;
    logic [1:0]       sel_q;
    logic             sel_chg;
    logic [CNT_W-1:0] sel_cnt;

    int checks = 0;
    int errors = 0;

    exp_reg_t reg_q[$];
    logic     comb_q[$];
    event     comb_ev;

    // Model state for the registered outputs.
    int m_sel = 0;
    int m_cnt = 0;
    int m_max = (1 << CNT_W) - 1;

    bit four_state = 1'b0;

    mux4to1_sel #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s0      (s0),
        .s1      (s1),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out     (out),
        .out_q   (out_q),
        .sel_q   (sel_q),
        .sel_chg (sel_chg),
        .sel_cnt (sel_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mux: an unknown select gives X, otherwise the chosen bit as is.
    function automatic logic ref_mux(input logic [1:0] sel, input logic [3:0] d);
        if ($isunknown(sel)) return 1'bx;
        return d[sel];
    endfunction

    // Random bit; X and Z only appear on a four-state simulator.
    function automatic logic pick_bit();
        int r;
        r = four_state ? $urandom_range(0, 3) : $urandom_range(0, 1);
        case (r)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'bx;
            default: return 1'bz;
        endcase
    endfunction

    // Combinational-only vector: apply, push expectation, let monitor sample.
    task automatic drive_comb(input logic v1, input logic v0, input logic [3:0] d);
        rst = 1'b0;
        s1  = v1;
        s0  = v0;
        {in3, in2, in1, in0} = d;
        comb_q.push_back(ref_mux({v1, v0}, d));
        #1 -> comb_ev;
        #1;
    endtask

    // One clock cycle of stimulus with the model advanced to the next edge.
    task automatic drive_cycle(input logic r, input logic [1:0] s, input logic [3:0] d);
        exp_reg_t e;
        @(negedge clk);
        rst = r;
        s1  = s[1];
        s0  = s[0];
        {in3, in2, in1, in0} = d;
        if (r) begin
            m_sel   = 0;
            m_cnt   = 0;
            e.out_q = 1'b0;
            e.sel   = 2'b00;
            e.chg   = 1'b0;
        end else begin
            e.out_q = ref_mux(s, d);
            e.sel   = s;
            e.chg   = (int'(s) != m_sel);
            if (e.chg && (m_cnt < m_max)) m_cnt = m_cnt + 1;
            m_sel   = int'(s);
        end
        e.cnt = m_cnt[CNT_W-1:0];
        reg_q.push_back(e);
        comb_q.push_back(ref_mux(s, d));
        #1 -> comb_ev;
    endtask

    // Combinational monitor.
    initial begin
        logic exp_out;
        forever begin
            @(comb_ev);
            if (comb_q.size() > 0) begin
                exp_out = comb_q.pop_front();
                checks++;
                if (out !== exp_out) begin
                    errors++;
                    $display("FAIL out: got %b expected %b (sel=%b%b in=%b%b%b%b) t=%0t",
                             out, exp_out, s1, s0, in3, in2, in1, in0, $time);
                end
            end
        end
    end

    // Registered monitor, sampled 1 unit after the rising edge.
    initial begin
        exp_reg_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                checks += 4;
                if (out_q !== e.out_q) begin
                    errors++;
                    $display("FAIL out_q: got %b expected %b t=%0t", out_q, e.out_q, $time);
                end
                if (sel_q !== e.sel) begin
                    errors++;
                    $display("FAIL sel_q: got %b expected %b t=%0t", sel_q, e.sel, $time);
                end
                if (sel_chg !== e.chg) begin
                    errors++;
                    $display("FAIL sel_chg: got %b expected %b t=%0t", sel_chg, e.chg, $time);
                end
                if (sel_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL sel_cnt: got %0d expected %0d t=%0t", sel_cnt, e.cnt, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Driver.
    initial begin
        logic       probe;
        logic [1:0] s;
        logic [3:0] d;

        probe      = 1'bx;
        four_state = $isunknown(probe);

        rst = 1'b0; s0 = 1'b0; s1 = 1'b0;
        in0 = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
        #2;

        // Select sweep with in3..in0 = 1010 -> 0,1,0,1.
        drive_comb(1'b0, 1'b0, 4'b1010);
        drive_comb(1'b0, 1'b1, 4'b1010);
        drive_comb(1'b1, 1'b0, 4'b1010);
        drive_comb(1'b1, 1'b1, 4'b1010);

        // Directed X cases.
        if (four_state) begin
            drive_comb(1'bx, 1'b0, 4'b1111);
            drive_comb(1'b0, 1'b1, 4'b00x0);
            drive_comb(1'b0, 1'b1, 4'b001x);
        end

        // Random vectors (0/1, plus X/Z on four-state simulators).
        for (int i = 0; i < 2000; i++) begin
            drive_comb(pick_bit(), pick_bit(),
                       {pick_bit(), pick_bit(), pick_bit(), pick_bit()});
        end

        // Reset two cycles, then hold select 11 with in3 = 1.
        drive_cycle(1'b1, 2'b00, 4'b0000);
        drive_cycle(1'b1, 2'b00, 4'b0000);
        drive_cycle(1'b0, 2'b11, 4'b1000);
        drive_cycle(1'b0, 2'b11, 4'b1000);

        // Saturation: reset, then toggle every cycle -> 1,2,3,3,3,3.
        drive_cycle(1'b1, 2'b00, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 4'($urandom));
        end

        // Mid-operation reset with data still moving.
        drive_cycle(1'b1, 2'b11, 4'b1000);
        drive_cycle(1'b0, 2'b10, 4'b0100);

        // Random cycles with occasional resets and held selects.
        s = 2'b00;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) s = 2'($urandom_range(0, 3));
            d = 4'($urandom);
            drive_cycle(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, s, d);
        end

        @(posedge clk);
        #3;
        checks++;
        if ((reg_q.size() != 0) || (comb_q.size() != 0)) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0",
                     reg_q.size(), comb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4to1_sel.md
Name: mux4to1_sel

Overview:
- Single-bit 4:1 multiplexer with a purely combinational data path. The 2-bit select is formed as {s1, s0}.
- Adds clocked bookkeeping: a registered copy of the output, the select value registered, a one-cycle pulse when the select changes, and a saturating count of select changes.
- Used as a drop-in mux wherever select/data bits come from control logic. The combinational output must be bit-identical to the team's behavioural mux, including X propagation in simulation.

Parameters:
- CNT_W, 8, width of the select-change counter sel_cnt (legal range 1..32).

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s0  in  1  select bit 0 (LSB).
- s1  in  1  select bit 1 (MSB).
- in0  in  1  data input chosen when {s1,s0}=00.
- in1  in  1  data input chosen when {s1,s0}=01.
- in2  in  1  data input chosen when {s1,s0}=10.
- in3  in  1  data input chosen when {s1,s0}=11.
- out  out  1  combinational mux output.
- out_q  out  1  out registered one cycle.
- sel_q  out  2  {s1,s0} registered one cycle.
- sel_chg  out  1  one-cycle pulse: the select differs from last cycle's value.
- sel_cnt  out  CNT_W  saturating count of select changes.

Behaviour:
- Combinational output (no clock or reset involvement, zero latency):
  - out = in0 / in1 / in2 / in3 for {s1,s0} = 00 / 01 / 10 / 11.
  - If either select bit is X or Z, out = X. Use a case statement whose default assigns 1'bx; do not resolve it to 0 or 1.
  - An X/Z value on the selected data input passes through unchanged.
  - Unselected inputs never affect out.
- Registered outputs, rising edge of clk:
  - rst=1: out_q=0, sel_q=00, sel_chg=0, sel_cnt=0. Reset takes priority over every other update, including mid-operation; outputs show reset values the cycle after rst is sampled high.
  - rst=0: out_q <= out; sel_q <= {s1,s0}.
  - rst=0: sel_chg <= 1 when {s1,s0} != sel_q, else 0.
  - rst=0: sel_cnt <= sel_cnt+1 when {s1,s0} != sel_q and sel_cnt < 2^CNT_W-1; it holds at all-ones (no wrap).
- First cycle after reset: sel_q=00, so a non-zero select on that cycle counts as a change.
- Select containing X/Z in simulation:
  - The comparison is X, so sel_chg is X and sel_cnt holds.
  - This behaviour is simulation-only and is not required to be synthesis-stable.
- Simultaneous select and data changes: out reflects the new select and the new data in the same delta; out_q captures whatever out is at the clock edge.
- No handshake. Every cycle is valid.

Optional Feature:
- Macro MUX4TO1_SEL_OUTREG_EN.
- When defined: out is driven from out_q, giving one-cycle latency, 0 during reset, and X propagated through the register.
- When undefined: out is the combinational mux as specified above.
- The port list is identical in both builds. out_q, sel_q, sel_chg and sel_cnt behave the same in both.

Test Plan:
- Select sweep, undefined build: in3..in0=1010, {s1,s0}=00,01,10,11 -> out=0,1,0,1 combinationally, each within the same timestep.
- X handling: s1=1'bx, s0=0 -> out=X; {s1,s0}=01 with in1=1'bx -> out=X; {s1,s0}=01 with in0=1'bx, in1=1 -> out=1. Check with !==/=== against the behavioural reference, 2000 random vectors mixing 0/1/X at 1-unit spacing.
- Registering: rst high 2 cycles -> out_q=0, sel_q=00, sel_cnt=0. Then hold {s1,s0}=11 with in3=1 -> cycle1: out_q=1, sel_q=11, sel_chg=1, sel_cnt=1. Cycle2: sel_chg=0, sel_cnt=1.
- Saturation, CNT_W=2: toggle select every cycle for 6 cycles -> sel_cnt 1,2,3,3,3,3; sel_chg=1 every cycle.
- Reset mid-operation: sel_cnt=3, assert rst one cycle -> next edge all registers 0 while out still follows inputs combinationally (undefined build).
- MUX4TO1_SEL_OUTREG_EN defined: {s1,s0}=10, in2=1 applied at edge N -> out=1 after edge N+1, and 0 while rst is high.
